bsg_dff_reset_en_pipe: RTL and testbench
========================================

Name: bsg_dff_reset_en_pipe

Overview:
Parametrised successor to the single-stage reset/enable register. It is a DEPTH-stage elastic register pipeline, WIDTH bits wide, with a programmable reset value per stage. Valid/ready handshakes are used at both ends, and bubbles collapse. It sits on datapath boundaries in the backend (e.g. between issue and execute) where a registered, stallable, reset-initialised payload is needed.

Parameters:
- WIDTH_P, 64, payload width in bits (>=1).
- DEPTH_P, 2, number of register stages (>=1).
- RESET_VAL_P, 64'h0000_0001_0000_0124, value loaded into every stage data register on reset (WIDTH_P bits).
- OCC_W_P, $clog2(DEPTH_P+1), width of the occupancy count (derived; not to be overridden).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset; assert async, deassert sync to clk_i externally.
- data_i  in  WIDTH_P  input payload.
- v_i  in  1  input valid.
- ready_o  out  1  pipeline can accept; input transfer = v_i & ready_o.
- data_o  out  WIDTH_P  payload of the last stage.
- v_o  out  1  last stage holds valid data.
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1.
- count_o  out  OCC_W_P  number of valid stages.

Behaviour:
- State: per stage k (0..DEPTH_P-1) data_r[k] (WIDTH_P) and v_r[k] (1). Stage 0 is the input end; stage DEPTH_P-1 drives data_o/v_o.
- Reset (reset_n_i=0, asynchronous): all data_r[k]=RESET_VAL_P, all v_r[k]=0. Outputs: v_o=0, data_o=RESET_VAL_P, count_o=0, ready_o=1 (combinational from the reset state).
- Stage advance enable, computed combinationally from the output end backward:
  - adv[DEPTH_P-1] = ~v_r[DEPTH_P-1] | yumi_i
  - adv[k] = ~v_r[k] | adv[k+1]
- ready_o = adv[0]. This is a combinational path from yumi_i, which is intentional for full throughput.
- On a clock edge, for each k with adv[k]=1:
  - v_r[k] <= upstream valid (v_i for k=0, v_r[k-1] otherwise).
  - data_r[k] <= upstream data, but only when the upstream valid is 1.
  - When adv[k]=0, the stage holds data and valid.
- Data registers never load on an invalid upstream. A bubble leaves the stale data_r in place, which is clock-gate friendly (the register enable is adv[k] & upstream valid).
- Latency: DEPTH_P cycles from input transfer to v_o, with no backpressure. Throughput is 1 transfer/cycle sustained while yumi_i is held high.
- Bubble collapse: an empty stage accepts even when downstream is stalled. Up to DEPTH_P items are buffered under a stall.
- Full: all v_r=1 and yumi_i=0 gives ready_o=0. If yumi_i=1 while full, ready_o=1 and the input is accepted in the same cycle.
- Empty: count_o=0, v_o=0. yumi_i while v_o=0 is illegal; there is no state effect beyond adv semantics, and assertions flag it.
- count_o = popcount(v_r). Next count = count + (v_i & ready_o) - yumi_i. A simultaneous push and pop leaves the count unchanged.
- Reset asserted mid-operation: all in-flight items are discarded immediately, data returns to RESET_VAL_P, and there is no partial transfer.
- DEPTH_P=1 degenerates to a single reset/enable register with valid and handshake.

Optional Feature:
- Macro: BSG_DFF_RESET_EN_PIPE_FLUSH_EN.
- When defined, the block adds input port flush_i (1 bit, synchronous).
  - On a rising edge with flush_i=1: all v_r <= 0 and all data_r <= RESET_VAL_P.
  - An input offered that cycle is dropped; ready_o is still computed normally.
  - flush_i takes priority over any advance.
  - yumi_i in a flush cycle is legal and is consumed.
- When not defined, the port is absent and flush is possible only via reset_n_i.

Test Plan:
1. Reset value check (WIDTH_P=64, DEPTH_P=3): pulse reset_n_i=0 mid-cycle -> data_o=64'h0000_0001_0000_0124, v_o=0, count_o=0, ready_o=1 immediately, without waiting for a clock edge.
2. Latency and throughput: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with yumi_i tied to v_o -> v_o rises 3 cycles after the first push; data_o sequence is 0x11, 0x22, 0x33, 0x44 with no gaps; count_o stays <=3.
3. Backpressure and full: yumi_i=0 and push 0xA, 0xB, 0xC -> count_o=3, ready_o=0. A fourth v_i is not accepted. Then yumi_i=1 with v_i=1 carrying 0xD -> data_o=0xA is consumed, 0xD is accepted, count_o stays 3.
4. Bubble collapse: push 0x1, idle 2 cycles, push 0x2, with yumi_i=0 -> both items end up in stages 2 and 1; count_o=2; data_o=0x1 held.
5. Reset mid-flight: with 2 items in flight, assert reset_n_i -> v_o=0 and data_o=RESET_VAL_P asynchronously. After release, the first new push 0x55 appears after 3 cycles.
6. (FLUSH_EN) Full pipe, flush_i=1 with v_i=1 carrying 0x77 -> next cycle count_o=0, v_o=0, data_o=RESET_VAL_P, and 0x77 never appears.

Source files
------------

// File: rtl/bsg_dff_reset_en_pipe_if.sv
// Handshake and payload bundle for bsg_dff_reset_en_pipe: producer side (data_i/v_i/ready_o),
// consumer side (data_o/v_o/yumi_i) and the occupancy count.
interface bsg_dff_reset_en_pipe_if #(
  parameter int WIDTH_P = 64,
  parameter int DEPTH_P = 2
);
  localparam int OCC_W_P = $clog2(DEPTH_P + 1);

  logic [WIDTH_P-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [WIDTH_P-1:0] data_o;
  logic               v_o;
  logic               yumi_i;
  logic [OCC_W_P-1:0] count_o;

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, data_o, v_o, count_o
  );

  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, data_o, v_o, count_o
  );
endinterface

// File: rtl/bsg_dff_reset_en_pipe.sv
// DEPTH_P-stage elastic register pipeline with per-stage reset value and collapsing bubbles.
// Optional synchronous flush port enabled by defining BSG_DFF_RESET_EN_PIPE_FLUSH_EN.
module bsg_dff_reset_en_pipe #(
  parameter int                 WIDTH_P     = 64,
  parameter int                 DEPTH_P     = 2,
  parameter logic [WIDTH_P-1:0] RESET_VAL_P = WIDTH_P'(64'h0000_0001_0000_0124),
  localparam int                OCC_W_P     = $clog2(DEPTH_P + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
`ifdef BSG_DFF_RESET_EN_PIPE_FLUSH_EN
  input  logic flush_i,
`endif
  bsg_dff_reset_en_pipe_if.slave io
);

  logic [DEPTH_P-1:0] v_q, v_d;
  logic [WIDTH_P-1:0] data_q [DEPTH_P];
  logic [WIDTH_P-1:0] data_d [DEPTH_P];
  logic [DEPTH_P-1:0] adv;
  logic [DEPTH_P-1:0] up_v;
  logic [WIDTH_P-1:0] up_data [DEPTH_P];
  logic [OCC_W_P-1:0] count;

  // A stage may advance if it is empty or the stage below it advances; the
  // ripple starts at the consumer, so ready_o sees yumi_i combinationally.
  // NOTE: a local running variable avoids reading adv inside its own
  // computation, which would form a false combinational loop on the vector.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = io.yumi_i;
    for (int k = DEPTH_P - 1; k >= 0; k--) begin
      carry  = ~v_q[k] | carry;
      adv[k] = carry;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    up_v       = '0;
    up_v[0]    = io.v_i;
    up_data[0] = io.data_i;
    for (int k = 1; k < DEPTH_P; k++) begin
      up_v[k]    = v_q[k-1];
      up_data[k] = data_q[k-1];
    end

    v_d    = v_q;
    data_d = data_q;
    for (int k = 0; k < DEPTH_P; k++) begin
      if (adv[k]) begin
        v_d[k] = up_v[k];
        // Bubbles leave stale data in place: the data enable is adv & upstream valid.
        if (up_v[k]) data_d[k] = up_data[k];
      end
    end

`ifdef BSG_DFF_RESET_EN_PIPE_FLUSH_EN
    if (flush_i) begin
      v_d = '0;
      for (int k = 0; k < DEPTH_P; k++) data_d[k] = RESET_VAL_P;
    end
`endif
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH_P; k++) count = count + OCC_W_P'(v_q[k]);
  end

  // NOTE: sequential state uses non-blocking assignments only; the data
  // registers are reset too, because data_o must show RESET_VAL_P out of reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH_P; k++) data_q[k] <= RESET_VAL_P;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign io.ready_o = adv[0];
  assign io.data_o  = data_q[DEPTH_P-1];
  assign io.v_o     = v_q[DEPTH_P-1];
  assign io.count_o = count;

  // The consumer may only take data that is actually presented.
  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) io.yumi_i |-> io.v_o
  );

endmodule

// File: tb/tb_bsg_dff_reset_en_pipe.sv
// Self-checking bench for bsg_dff_reset_en_pipe (WIDTH_P=64, DEPTH_P=3) using a
// queue scoreboard of accepted payloads that is popped as the consumer takes data.
module tb_bsg_dff_reset_en_pipe;
  localparam int          W  = 64;
  localparam int          D  = 3;
  localparam logic [63:0] RV = 64'h0000_0001_0000_0124;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b1;
  logic flush_i   = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb [$];
  logic [63:0] mon_exp;

  bsg_dff_reset_en_pipe_if #(.WIDTH_P(W), .DEPTH_P(D)) pif ();

  bsg_dff_reset_en_pipe #(.WIDTH_P(W), .DEPTH_P(D), .RESET_VAL_P(RV)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
`ifdef BSG_DFF_RESET_EN_PIPE_FLUSH_EN
    .flush_i   (flush_i),
`endif
    .io        (pif.slave)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: inputs are stable mid-cycle, so the negedge sees exactly what the
  // following posedge will act on.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (pif.yumi_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_pop: data_o=%h taken but no item expected", pif.data_o);
        end else begin
          mon_exp = sb.pop_front();
          if (pif.data_o !== mon_exp) begin
            bad++;
            $display("FAIL sb_data: data_o=%h expected %h", pif.data_o, mon_exp);
          end
        end
      end
      if (flush_i) sb.delete();
      else if (pif.v_i && pif.ready_o) sb.push_back(pif.data_i);
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    pif.v_i = 1'b0;
    while ((pif.v_o || sb.size() != 0) && c < 20) begin
      pif.yumi_i = pif.v_o;
      next_cycle();
      c++;
    end
    pif.yumi_i = 1'b0;
    total++;
    if (pif.v_o !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: v_o=%b left=%0d required empty", tag, pif.v_o, sb.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #3;
    reset_n_i = 1'b0;
    #1;
    total += 4;
    if (pif.data_o !== RV) begin
      bad++; $display("FAIL rst_data: data_o=%h expected %h", pif.data_o, RV);
    end
    if (pif.v_o !== 1'b0) begin
      bad++; $display("FAIL rst_v: v_o=%b expected 0", pif.v_o);
    end
    if (pif.count_o !== 2'd0) begin
      bad++; $display("FAIL rst_count: count_o=%0d expected 0", pif.count_o);
    end
    if (pif.ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_ready: ready_o=%b expected 1", pif.ready_o);
    end
    repeat (2) next_cycle();
    reset_n_i = 1'b1;
    sb.delete();
    next_cycle();
  endtask

  task automatic test_latency_throughput();
    logic [63:0] vals [4];
    logic [63:0] got [$];
    int first_v, last_pop, max_cnt;
    vals     = '{64'h11, 64'h22, 64'h33, 64'h44};
    first_v  = -1;
    last_pop = -1;
    max_cnt  = 0;
    for (int c = 0; c < 12; c++) begin
      pif.v_i    = (c < 4);
      pif.data_i = (c < 4) ? vals[c] : 64'h0;
      pif.yumi_i = pif.v_o;
      #1;
      if (pif.v_o && first_v < 0) first_v = c;
      if (pif.v_o && pif.yumi_i) begin
        got.push_back(pif.data_o);
        last_pop = c;
      end
      if (int'(pif.count_o) > max_cnt) max_cnt = int'(pif.count_o);
      next_cycle();
    end
    pif.v_i    = 1'b0;
    pif.yumi_i = 1'b0;
    total += 3;
    if (first_v !== 3) begin
      bad++; $display("FAIL lat_first: v_o after %0d cycles expected 3", first_v);
    end
    if (last_pop - first_v !== 3 || got.size() !== 4) begin
      bad++; $display("FAIL lat_gapless: pops=%0d span=%0d expected 4 and 3", got.size(), last_pop - first_v);
    end
    if (max_cnt > 3) begin
      bad++; $display("FAIL lat_count: max count_o=%0d expected <=3", max_cnt);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i] !== vals[i]) begin
        bad++; $display("FAIL lat_order%0d: data_o=%h expected %h", i, got[i], vals[i]);
      end
    end
    drain("lat");
  endtask

  task automatic test_backpressure_full();
    logic [63:0] vals [3];
    vals       = '{64'hA, 64'hB, 64'hC};
    pif.yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pif.v_i    = 1'b1;
      pif.data_i = vals[i];
      next_cycle();
    end
    pif.v_i    = 1'b1;
    pif.data_i = 64'hEE;
    #1;
    total += 2;
    if (pif.count_o !== 2'd3) begin
      bad++; $display("FAIL full_count: count_o=%0d expected 3", pif.count_o);
    end
    if (pif.ready_o !== 1'b0) begin
      bad++; $display("FAIL full_ready: ready_o=%b expected 0", pif.ready_o);
    end
    next_cycle();
    total += 2;
    if (pif.count_o !== 2'd3) begin
      bad++; $display("FAIL full_hold: count_o=%0d expected 3", pif.count_o);
    end
    if (pif.data_o !== 64'hA) begin
      bad++; $display("FAIL full_head: data_o=%h expected a", pif.data_o);
    end
    pif.yumi_i = 1'b1;
    pif.data_i = 64'hD;
    #1;
    total++;
    if (pif.ready_o !== 1'b1) begin
      bad++; $display("FAIL full_passthru_ready: ready_o=%b expected 1", pif.ready_o);
    end
    next_cycle();
    pif.v_i    = 1'b0;
    pif.yumi_i = 1'b0;
    #1;
    total += 2;
    if (pif.count_o !== 2'd3) begin
      bad++; $display("FAIL full_pushpop_count: count_o=%0d expected 3", pif.count_o);
    end
    if (pif.data_o !== 64'hB) begin
      bad++; $display("FAIL full_next_head: data_o=%h expected b", pif.data_o);
    end
    drain("full");
  endtask

  task automatic test_bubble_collapse();
    pif.yumi_i = 1'b0;
    pif.v_i    = 1'b1;
    pif.data_i = 64'h1;
    next_cycle();
    pif.v_i = 1'b0;
    repeat (2) next_cycle();
    pif.v_i    = 1'b1;
    pif.data_i = 64'h2;
    next_cycle();
    pif.v_i = 1'b0;
    repeat (3) next_cycle();
    total += 4;
    if (pif.count_o !== 2'd2) begin
      bad++; $display("FAIL bub_count: count_o=%0d expected 2", pif.count_o);
    end
    if (pif.v_o !== 1'b1 || pif.data_o !== 64'h1) begin
      bad++; $display("FAIL bub_head: v_o=%b data_o=%h expected 1 and 1", pif.v_o, pif.data_o);
    end
    if (dut.v_q !== 3'b110) begin
      bad++; $display("FAIL bub_stages: v_q=%b expected 110", dut.v_q);
    end
    if (pif.ready_o !== 1'b1) begin
      bad++; $display("FAIL bub_ready: ready_o=%b expected 1", pif.ready_o);
    end
    drain("bub");
  endtask

  task automatic test_reset_midflight();
    int lat;
    logic [63:0] seen;
    lat        = -1;
    seen       = '0;
    pif.yumi_i = 1'b0;
    pif.v_i    = 1'b1;
    pif.data_i = 64'h61;
    next_cycle();
    pif.data_i = 64'h62;
    next_cycle();
    pif.v_i = 1'b0;
    repeat (2) next_cycle();
    total++;
    if (pif.v_o !== 1'b1 || pif.data_o !== 64'h61) begin
      bad++; $display("FAIL mid_pre: v_o=%b data_o=%h expected 1 and 61", pif.v_o, pif.data_o);
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    total += 3;
    if (pif.v_o !== 1'b0) begin
      bad++; $display("FAIL mid_rst_v: v_o=%b expected 0", pif.v_o);
    end
    if (pif.data_o !== RV) begin
      bad++; $display("FAIL mid_rst_data: data_o=%h expected %h", pif.data_o, RV);
    end
    if (pif.count_o !== 2'd0) begin
      bad++; $display("FAIL mid_rst_count: count_o=%0d expected 0", pif.count_o);
    end
    sb.delete();
    next_cycle();
    reset_n_i  = 1'b1;
    pif.v_i    = 1'b1;
    pif.data_i = 64'h55;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) pif.v_i = 1'b0;
      #1;
      if (pif.v_o && lat < 0) begin
        lat  = c;
        seen = pif.data_o;
      end
      next_cycle();
    end
    total += 2;
    if (lat !== 3) begin
      bad++; $display("FAIL mid_latency: v_o after %0d cycles expected 3", lat);
    end
    if (seen !== 64'h55) begin
      bad++; $display("FAIL mid_data: data_o=%h expected 55", seen);
    end
    drain("mid");
  endtask

`ifdef BSG_DFF_RESET_EN_PIPE_FLUSH_EN
  task automatic test_flush();
    logic saw;
    saw        = 1'b0;
    pif.yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pif.v_i    = 1'b1;
      pif.data_i = 64'h71 + 64'(i);
      next_cycle();
    end
    flush_i    = 1'b1;
    pif.v_i    = 1'b1;
    pif.data_i = 64'h77;
    #1;
    total++;
    if (pif.ready_o !== 1'b0) begin
      bad++; $display("FAIL fl_ready: ready_o=%b expected 0", pif.ready_o);
    end
    next_cycle();
    flush_i = 1'b0;
    pif.v_i = 1'b0;
    total += 3;
    if (pif.count_o !== 2'd0) begin
      bad++; $display("FAIL fl_count: count_o=%0d expected 0", pif.count_o);
    end
    if (pif.v_o !== 1'b0) begin
      bad++; $display("FAIL fl_v: v_o=%b expected 0", pif.v_o);
    end
    if (pif.data_o !== RV) begin
      bad++; $display("FAIL fl_data: data_o=%h expected %h", pif.data_o, RV);
    end
    for (int c = 0; c < 6; c++) begin
      if (pif.v_o) saw = 1'b1;
      next_cycle();
    end
    total++;
    if (saw !== 1'b0) begin
      bad++; $display("FAIL fl_dropped: v_o rose after flush, data_o=%h", pif.data_o);
    end
    drain("fl");
  endtask
`endif

  initial begin
    pif.data_i = '0;
    pif.v_i    = 1'b0;
    pif.yumi_i = 1'b0;
    test_reset();
    test_latency_throughput();
    test_backpressure_full();
    test_bubble_collapse();
    test_reset_midflight();
`ifdef BSG_DFF_RESET_EN_PIPE_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
